param_lifo_stack: RTL

Parametrised LIFO stack that replaces the fixed 4-bit x 16-entry stack in the call/return path. It provides configurable data width and depth, registered pop data with a valid strobe, a combinational top-of-stack peek, an atomic push+pop (replace-top) operation, an occupancy count, an almost-full threshold, and sticky overflow/underflow error flags. A two-source input select (data operand vs. PC) is folded into the block.

---
 rtl/param_lifo_stack.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack for the call/return path. It has a registered pop port,
// a combinational top-of-stack peek, a replace-top operation and sticky error flags.
module param_lifo_stack #(
    parameter int DATA_W       = 4,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              src_sel,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_PUSH_FULL,
        OP_POP,
        OP_POP_EMPTY,
        OP_REPLACE,
        OP_PUSH_POP_EMPTY
    } op_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              overflow_q, underflow_q;

    logic [DATA_W-1:0] wdata;
    logic [IDX_W-1:0]  top_idx, next_idx;
    op_t               op;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic              dout_load;
    logic              ovf_set, udf_set;

    assign wdata = src_sel ? data_in : pc_in;

    // Indices are only used when the guarding flag (empty/full) says they are in range.
    assign top_idx  = IDX_W'(count_q - CNT_W'(1));
    assign next_idx = IDX_W'(count_q);

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(AFULL_THRESH));
    assign top         = empty ? '0 : mem[top_idx];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        op = OP_IDLE;
        unique case ({push, pop})
            2'b10:   op = full  ? OP_PUSH_FULL      : OP_PUSH;
            2'b01:   op = empty ? OP_POP_EMPTY      : OP_POP;
            2'b11:   op = empty ? OP_PUSH_POP_EMPTY : OP_REPLACE;
            default: op = OP_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = next_idx;
        count_nxt = count_q;
        dout_load = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        unique case (op)
            OP_PUSH: begin
                mem_we    = 1'b1;
                count_nxt = count_q + CNT_W'(1);
            end
            OP_PUSH_FULL: ovf_set = 1'b1;
            OP_POP: begin
                dout_load = 1'b1;
                count_nxt = count_q - CNT_W'(1);
            end
            OP_POP_EMPTY: udf_set = 1'b1;
            OP_REPLACE: begin
                mem_we    = 1'b1;
                mem_waddr = top_idx;
                dout_load = 1'b1;
            end
            OP_PUSH_POP_EMPTY: begin
                mem_we    = 1'b1;
                count_nxt = count_q + CNT_W'(1);
                udf_set   = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: storage has no reset; an empty stack masks stale contents through top.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= wdata;
        end
    end

    // NOTE: non-blocking assignments let replace-top read the old entry in the same edge it is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_nxt;
            dout_valid_q <= dout_load;
            if (dout_load) begin
                dout_q <= mem[top_idx];
            end
            // A new error event wins over a simultaneous clear.
            overflow_q  <= ovf_set | (overflow_q  & ~clr_err);
            underflow_q <= udf_set | (underflow_q & ~clr_err);
        end
    end

    assign count      = count_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
